// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M/RV64M multiply/divide unit.
//   muldiv_op_e    : funct3 encoding of the eight M-extension operations
//   muldiv_state_e : control FSM states of muldiv_unit
//   XLEN_DEFAULT   : default operand width
package rv32_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response channel between the execute stage and muldiv_unit.
//   master : execute stage (drives request, flush, resp_ready_i)
//   slave  : muldiv_unit   (drives req_ready_o, response, busy_o)
interface muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       req_op_i;
    logic [XLEN-1:0]  req_a_i;
    logic [XLEN-1:0]  req_b_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             flush_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [XLEN-1:0]  resp_data_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic             busy_o;

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_tag_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, flush_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_tag_o, busy_o
    );
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divider core for unsigned magnitudes.
//   start    : load dividend/divisor, begin XLEN iterations (MSB first)
//   kill     : abandon the current division
//   done     : high in the cycle computing the last quotient bit; quot/rem
//              are valid from the following cycle
//   quot/rem : unsigned quotient and remainder
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);
    localparam int CW = $clog2(XLEN);

    logic            run;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] q_q, r_q, dvs_q;
    logic [XLEN:0]   shifted, trial;

    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the partial remainder while the new quotient bit enters at the LSB.
    always_comb begin
        shifted = {r_q, q_q[XLEN-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    assign done = run && (cnt == CW'(XLEN - 1));
    assign quot = q_q;
    assign rem  = r_q;

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            run   <= 1'b0;
            cnt   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dvs_q <= '0;
        end else if (start) begin
            run   <= 1'b1;
            cnt   <= '0;
            q_q   <= dividend;
            r_q   <= '0;
            dvs_q <= divisor;
        end else if (run) begin
            run <= !done;
            cnt <= done ? '0 : cnt + 1'b1;
            // Restore when the trial subtraction borrows.
            if (!trial[XLEN]) begin
                r_q <= trial[XLEN-1:0];
                q_q <= {q_q[XLEN-2:0], 1'b1};
            end else begin
                r_q <= shifted[XLEN-1:0];
                q_q <= {q_q[XLEN-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_unit_if.slave -- one op at a time over valid/ready,
//              tagged result on a valid/ready response, flush_i aborts.
// Multiply latency MUL_STAGES cycles; divide by zero / signed overflow 1
// cycle; normal divide XLEN+2 cycles (XLEN iterations + sign fixup).
module muldiv_unit
    import rv32_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    // Registers between the multiplier and the response register; the
    // response register itself is the last of the MUL_STAGES stages.
    localparam int PW = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e state_q, state_d;

    logic            accept, is_div, is_rem, sgn_div;
    logic            a_neg, b_neg, b_zero, ovf, special;
    logic [XLEN-1:0] a, b, mag_a, mag_b, spec_res;

    logic              mul_a_sgn, mul_b_sgn, mul_done;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   mpipe [PW];
    logic [PW-1:0]     vld_pipe;

    logic            div_done;
    logic [XLEN-1:0] div_q, div_r, fix_res, load_val;
    logic            neg_q_q, neg_r_q, rem_sel_q;

    logic             resp_valid_q;
    logic [XLEN-1:0]  resp_data_q;
    logic [TAG_W-1:0] resp_tag_q;

    assign a = bus.req_a_i;
    assign b = bus.req_b_i;

    // rst is folded in so the unit never advertises ready while in reset.
    assign bus.req_ready_o  = (state_q == ST_IDLE) && !bus.flush_i && !rst;
    assign accept           = bus.req_valid_i && bus.req_ready_o;
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_data_o  = resp_data_q;
    assign bus.resp_tag_o   = resp_tag_q;

    assign is_div  = bus.req_op_i[2];
    assign is_rem  = bus.req_op_i[1];
    assign sgn_div = is_div && !bus.req_op_i[0];

    // ---- multiply: one wide product, registers after it for retiming ----
    // Sign-extending to 2*XLEN makes the truncated unsigned product equal to
    // the exact signed/unsigned product for every signedness mix.
    always_comb begin
        mul_a_sgn = (bus.req_op_i == OP_MULH) || (bus.req_op_i == OP_MULHSU);
        mul_b_sgn = (bus.req_op_i == OP_MULH);
        mul_a     = {{XLEN{mul_a_sgn & a[XLEN-1]}}, a};
        mul_b     = {{XLEN{mul_b_sgn & b[XLEN-1]}}, b};
        mul_p     = mul_a * mul_b;
        mul_res   = (bus.req_op_i == OP_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (accept) mpipe[0] <= mul_res;
        for (int i = 1; i < PW; i++) mpipe[i] <= mpipe[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept && !is_div;
            for (int i = 1; i < PW; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign mul_done = vld_pipe[PW-1];

    // ---- divide: special cases resolved at accept, else iterate ----
    always_comb begin
        a_neg    = sgn_div && a[XLEN-1];
        b_neg    = sgn_div && b[XLEN-1];
        mag_a    = a_neg ? -a : a;
        mag_b    = b_neg ? -b : b;
        b_zero   = (b == '0);
        ovf      = sgn_div && (a == MOST_NEG) && (b == '1);
        special  = b_zero || ovf;
        if (b_zero) spec_res = is_rem ? a : '1;
        else        spec_res = is_rem ? '0 : a;
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .kill     (bus.flush_i),
        .start    (accept && is_div && !special),
        .dividend (mag_a),
        .divisor  (mag_b),
        .done     (div_done),
        .quot     (div_q),
        .rem      (div_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (accept) begin
            neg_q_q   <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            rem_sel_q <= is_rem;
        end
    end

    always_comb begin
        if (rem_sel_q) fix_res = neg_r_q ? -div_r : div_r;
        else           fix_res = neg_q_q ? -div_q : div_q;
    end

    // ---- control FSM ----
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_div) begin
                        if (MUL_STAGES == 1) state_d = ST_DONE;
                        else                 state_d = ST_MUL;
                    end else if (special) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DIV:  if (div_done) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (bus.resp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush_i) state_d = ST_IDLE;
    end

    // Result captured on the edge that enters DONE.
    always_comb begin
        case (state_q)
            ST_IDLE: load_val = is_div ? spec_res : mul_res;
            ST_MUL:  load_val = mpipe[PW-1];
            default: load_val = fix_res;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            resp_valid_q <= (state_d == ST_DONE);
            if (state_d == ST_DONE && state_q != ST_DONE) resp_data_q <= load_val;
            if (accept) resp_tag_q <= bus.req_tag_i;
        end
    end
endmodule
